// File: rtl/rrf_pkg.sv
// Shared types and constants for the rename-register-file allocator.
package rrf_pkg;

  localparam int unsigned RRF_DEPTH = 8;
  localparam int unsigned TAG_W     = 3;

  typedef logic [TAG_W-1:0]     rrf_tag_t;
  typedef logic [RRF_DEPTH-1:0] rrf_vec_t;
  typedef logic [TAG_W:0]       rrf_cnt_t;

  typedef enum logic {RUN, FLUSH} rrf_state_e;

  // Number of free entries in a vector.
  function automatic rrf_cnt_t rrf_popcount(input rrf_vec_t vec);
    rrf_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < RRF_DEPTH; i++) begin
      cnt = cnt + rrf_cnt_t'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rrf_pick2.sv
// Two-lowest-set-bit priority encoder over the free vector.
module rrf_pick2
  import rrf_pkg::*;
(
  input  rrf_vec_t vec,
  output rrf_tag_t p0,
  output rrf_tag_t p1,
  output logic     cnt_ge1,
  output logic     cnt_ge2
);

  // Scan from tag 0 upwards; first hit is p0, second is p1.
  always_comb begin
    p0      = '0;
    p1      = '0;
    cnt_ge1 = 1'b0;
    cnt_ge2 = 1'b0;
    for (int i = 0; i < RRF_DEPTH; i++) begin
      if (vec[i]) begin
        if (!cnt_ge1) begin
          p0      = rrf_tag_t'(i);
          cnt_ge1 = 1'b1;
        end else if (!cnt_ge2) begin
          p1      = rrf_tag_t'(i);
          cnt_ge2 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF free-list owner: dual allocate, dual reclaim, flush restore.
module rrf_alloc_ctrl
  import rrf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_W-1:0]     rr0,
  output logic [TAG_W-1:0]     rr1,
  output logic                 stall,
  input  logic [1:0]           free_vld,
  input  logic [TAG_W-1:0]     free_tag0,
  input  logic [TAG_W-1:0]     free_tag1,
  input  logic                 flush,
  output logic [RRF_DEPTH-1:0] free_rrf,
  output logic [TAG_W:0]       free_cnt,
  output logic                 rrf_full,
  output logic                 dbl_free_err
);

  rrf_state_e state_q, state_d;
  rrf_vec_t   vec_q, vec_d;
  rrf_cnt_t   cnt_q, cnt_d;
  logic       full_q;
  logic       err_q, err_d;

  rrf_tag_t   p0, p1;
  logic       cnt_ge1, cnt_ge2;
  rrf_vec_t   gnt_mask, free_mask;
  logic       dbl;

  rrf_pick2 u_pick (
    .vec     (vec_q),
    .p0      (p0),
    .p1      (p1),
    .cnt_ge1 (cnt_ge1),
    .cnt_ge2 (cnt_ge2)
  );

  // Grant, tag outputs, masks and next state of FSM, vector and error flag.
  always_comb begin
    alloc_gnt = 1'b0;
    if (!rst && state_q == RUN && !flush && (alloc_req != 2'b00)) begin
      alloc_gnt = (alloc_req == 2'b11) ? cnt_ge2 : cnt_ge1;
    end
    rr0   = alloc_gnt ? p0 : '0;
    rr1   = (alloc_gnt && alloc_req == 2'b11) ? p1 : '0;
    stall = (alloc_req != 2'b00) && !alloc_gnt;

    gnt_mask = '0;
    if (alloc_gnt) begin
      gnt_mask[p0] = 1'b1;
      if (alloc_req == 2'b11) gnt_mask[p1] = 1'b1;
    end

    free_mask = '0;
    if (free_vld[0]) free_mask[free_tag0] = 1'b1;
    if (free_vld[1]) free_mask[free_tag1] = 1'b1;

    dbl = (free_vld[0] && vec_q[free_tag0]) ||
          (free_vld[1] && vec_q[free_tag1]) ||
          (free_vld == 2'b11 && free_tag0 == free_tag1);

    // flush is the only way into FLUSH and FLUSH lasts while flush stays high.
    state_d = flush ? FLUSH : RUN;

    // Frees arriving with a flush or during FLUSH are dropped.
    if (flush || state_q == FLUSH) begin
      vec_d = '1;
      err_d = err_q;
    end else begin
      vec_d = (vec_q & ~gnt_mask) | free_mask;
      err_d = err_q | dbl;
    end
    cnt_d = rrf_popcount(vec_d);
  end

  // State, free vector, count and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      vec_q   <= '1;
      cnt_q   <= rrf_cnt_t'(RRF_DEPTH);
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d < rrf_cnt_t'(2));
      err_q   <= err_d;
    end
  end

  assign free_rrf     = vec_q;
  assign free_cnt     = cnt_q;
  assign rrf_full     = full_q;
  assign dbl_free_err = err_q;

endmodule

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
Owns the rename-register-file (RRF) free list for the dual-issue front end. It allocates up to two RRF tags per cycle to the dispatch slots, which rename in order. It reclaims up to two tags per cycle from commit and restores the full free list on a pipeline flush. It drives the 8-bit free vector consumed by the rename pick logic and tracks the free-entry count.

Parameters:
RRF_DEPTH, 8, number of rename registers
TAG_W, 3, tag width (log2 RRF_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
alloc_req  in  2  bit0 = slot0 needs a tag, bit1 = slot1 needs a tag
alloc_gnt  out  1  requested tags granted this cycle (combinational)
rr0  out  TAG_W  tag for first requesting slot; valid when alloc_gnt
rr1  out  TAG_W  tag for second requesting slot; valid when alloc_gnt and both bits of alloc_req are set
stall  out  1  alloc_req nonzero and alloc_gnt low
free_vld  in  2  commit frees; bit i qualifies free_tag_i
free_tag0  in  TAG_W  tag released by commit port 0
free_tag1  in  TAG_W  tag released by commit port 1
flush  in  1  pipeline flush: all tags return to free
free_rrf  out  RRF_DEPTH  registered free vector, bit j = tag j free
free_cnt  out  TAG_W+1  registered popcount of free_rrf, range 0..8
rrf_full  out  1  free_cnt < 2 (registered)
dbl_free_err  out  1  sticky: a free targeted an already-free tag

Behaviour:
- Reset (rst high at clk edge): free_rrf = all ones, free_cnt = 8, rrf_full = 0, dbl_free_err = 0, state = RUN. During rst, alloc_gnt = 0 and rr0/rr1 = 0.
- State machine has two states, RUN and FLUSH.
  - RUN → FLUSH when flush = 1.
  - FLUSH → RUN after one cycle, unless flush is still high, which holds FLUSH.
  - In FLUSH, alloc_gnt = 0 and stall = alloc_req != 0. free_rrf is forced to all ones and free_cnt to 8 at each edge.
  - dbl_free_err is not cleared by flush.
- Pick rule: combinational; selects the two lowest-index set bits of the current registered free_rrf, giving p0 < p1.
- Tag mapping:
  - A single request on either slot receives p0 on rr0.
  - When both bits of alloc_req are set, slot0 receives p0 on rr0 and slot1 receives p1 on rr1.
  - Unused tag outputs drive 0, never X/Z.
- Grant is all-or-nothing, so dispatch stays in order:
  - alloc_gnt = 1 iff state = RUN, flush = 0, and free_cnt is at least the number of requests.
  - Two requests with free_cnt = 1 gives no grant and stall = 1.
  - alloc_req = 0 gives alloc_gnt = 0.
- Update at each edge in RUN:
  - next free_rrf = (free_rrf & ~granted_mask) | freed_mask.
  - free_cnt is recomputed to match next free_rrf.
  - Latency: a freed tag is allocatable in the following cycle; there is no same-cycle bypass.
- Boundary conditions:
  - Both free ports carrying the same tag in one cycle: counted once and sets dbl_free_err.
  - A free of a tag whose bit is already 1: the vector is unchanged for that bit and dbl_free_err is set.
  - A free and an allocation of different tags in one cycle are both applied.
  - A grant can never select a tag being freed in the same cycle, because the pick uses the registered vector.
  - flush takes priority over alloc_req and free_vld in the same cycle; those frees are dropped.
  - rst takes priority over everything, including mid-FLUSH.
- Invariant: free_cnt == popcount(free_rrf) at all times. The bench must check this every cycle.

Decomposition:
- Shared package rrf_pkg:
  - RRF_DEPTH and TAG_W constants.
  - rrf_tag_t typedef (TAG_W bits).
  - rrf_vec_t typedef (RRF_DEPTH bits).
  - State enum {RUN, FLUSH}.
- Sub-module rrf_pick2:
  - Combinational two-lowest-set-bit priority encoder.
  - Inputs: rrf_vec_t.
  - Outputs: p0, p1, cnt_ge1, cnt_ge2.
  - The controller instantiates it once.
- The controller contains the FSM, the vector and count registers, free-mask decode, and error tracking.

Test Plan:
- Reset then alloc_req = 11 → alloc_gnt = 1, rr0 = 0, rr1 = 1; next cycle free_rrf = 8'b11111100, free_cnt = 6.
- Issue alloc_req = 11 for four cycles, then alloc_req = 01 → grants tags 0/1, 2/3, 4/5, 6/7; then stall = 1, free_cnt = 0, rrf_full = 1.
- With only tag 7 free: alloc_req = 11 → alloc_gnt = 0, stall = 1, vector unchanged; alloc_req = 10 the next cycle → grant with rr0 = 7.
- From the full state: free_vld = 11 with tags 3 and 5 while alloc_req = 11 → no grant that cycle; next cycle grants rr0 = 3, rr1 = 5.
- Free tag 2 when it is already free, or free_tag0 = free_tag1 = 4 → dbl_free_err = 1, held until rst; free_cnt stays consistent with the vector.
- After 6 tags are allocated, assert flush for one cycle together with alloc_req = 11 and free_vld = 01 → alloc_gnt = 0 in that cycle and the FLUSH cycle; free_rrf = 8'hFF, free_cnt = 8; a grant of rr0 = 0, rr1 = 1 resumes in the RUN cycle that follows.
